// File: rtl/rv32i_pkg.sv
// RV32I decode types shared by the decode/issue slice: opcode values,
// immediate format selector and the registered decode bundle.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] imm;
        imm_type_e       imm_type;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            illegal;
    } dec_bundle_t;

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry skid buffer (main + skid) with registered in_ready and a
// synchronous flush that discards both entries and the same-cycle input.
module decode_skid_buf
    import rv32i_pkg::*;
#(
    parameter type T = dec_bundle_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic main_valid_r;
    logic skid_valid_r;
    T     main_r;
    T     skid_r;
    logic accept_s;
    logic drain_s;

    assign in_ready  = ~skid_valid_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_r;
    assign accept_s  = in_valid & ~skid_valid_r & ~flush;
    assign drain_s   = main_valid_r & out_ready;

    // Entry state: refill main from skid first so ordering is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_r       <= '0;
            skid_r       <= '0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!main_valid_r || drain_s) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                main_r       <= in_data;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= in_data;
            skid_valid_r <= 1'b1;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

endmodule

// File: rtl/immediate_generation.sv
// Immediate datapath: produces every RV32I immediate format in parallel,
// sign-extended to 32 bits; the caller selects one by opcode.
module immediate_generation (
    input  logic [31:0] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    logic unused_opcode_s;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode bits never contribute to an immediate.
    assign unused_opcode_s = ^instr[6:0];

endmodule

// File: rtl/decode_issue_ctrl.sv
// RV32I decode-stage controller: classifies the opcode, selects the immediate
// and buffers the decoded bundle. Optional counters under DECODE_PERF_CNT_EN.
module decode_issue_ctrl
    import rv32i_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_instr,
    input  logic [DataWidth-1:0] in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_pc,
    output logic [DataWidth-1:0] out_instr,
    output logic [DataWidth-1:0] out_imm,
    output imm_type_e            out_imm_type,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
`ifdef DECODE_PERF_CNT_EN
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_illegal,
`endif
    output logic                 out_illegal
);

    logic [31:0] imm_itype_s;
    logic [31:0] imm_stype_s;
    logic [31:0] imm_btype_s;
    logic [31:0] imm_utype_s;
    logic [31:0] imm_jtype_s;
    logic [31:0] imm_sel_s;
    imm_type_e   imm_type_s;
    logic        illegal_s;
    dec_bundle_t in_bundle_s;
    dec_bundle_t out_bundle_s;

    immediate_generation u_immgen (
        .instr (in_instr),
        .imm_i (imm_itype_s),
        .imm_s (imm_stype_s),
        .imm_b (imm_btype_s),
        .imm_u (imm_utype_s),
        .imm_j (imm_jtype_s)
    );

    // Opcode classification; every listed opcode ends in 2'b11, so a
    // compressed-space encoding always falls through to the illegal default.
    always_comb begin
        imm_type_s = IMM_NONE;
        illegal_s  = 1'b0;
        case (in_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: imm_type_s = IMM_I;
            OPC_STORE:            imm_type_s = IMM_S;
            OPC_BRANCH:           imm_type_s = IMM_B;
            OPC_LUI, OPC_AUIPC:   imm_type_s = IMM_U;
            OPC_JAL:              imm_type_s = IMM_J;
            OPC_OP:               imm_type_s = IMM_NONE;
            default: begin
                imm_type_s = IMM_NONE;
                illegal_s  = 1'b1;
            end
        endcase
    end

    // Immediate select mux driven by the decoded format.
    always_comb begin
        imm_sel_s = 32'h0000_0000;
        case (imm_type_s)
            IMM_I:   imm_sel_s = imm_itype_s;
            IMM_S:   imm_sel_s = imm_stype_s;
            IMM_B:   imm_sel_s = imm_btype_s;
            IMM_U:   imm_sel_s = imm_utype_s;
            IMM_J:   imm_sel_s = imm_jtype_s;
            default: imm_sel_s = 32'h0000_0000;
        endcase
    end

    assign in_bundle_s.pc       = in_pc;
    assign in_bundle_s.instr    = in_instr;
    assign in_bundle_s.imm      = imm_sel_s;
    assign in_bundle_s.imm_type = imm_type_s;
    assign in_bundle_s.rd       = in_instr[11:7];
    assign in_bundle_s.rs1      = in_instr[19:15];
    assign in_bundle_s.rs2      = in_instr[24:20];
    assign in_bundle_s.illegal  = illegal_s;

    decode_skid_buf #(
        .T (dec_bundle_t)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bundle_s)
    );

    assign out_pc       = out_bundle_s.pc;
    assign out_instr    = out_bundle_s.instr;
    assign out_imm      = out_bundle_s.imm;
    assign out_imm_type = out_bundle_s.imm_type;
    assign out_rd       = out_bundle_s.rd;
    assign out_rs1      = out_bundle_s.rs1;
    assign out_rs2      = out_bundle_s.rs2;
    assign out_illegal  = out_bundle_s.illegal;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_illegal_r;
    logic        issue_hs_s;

    assign issue_hs_s = out_valid & out_ready;

    // Delivery counters; a flush does not clear them and they wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_r  <= 32'h0000_0000;
            perf_illegal_r <= 32'h0000_0000;
        end else if (issue_hs_s) begin
            perf_issued_r  <= perf_issued_r + 32'd1;
            perf_illegal_r <= perf_illegal_r + {31'd0, out_illegal};
        end else begin
            perf_issued_r  <= perf_issued_r;
            perf_illegal_r <= perf_illegal_r;
        end
    end

    assign perf_issued  = perf_issued_r;
    assign perf_illegal = perf_illegal_r;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed self-checking bench for decode_issue_ctrl: reset, decode formats,
// streaming, backpressure, illegal opcodes, flush and mid-stream reset.
module tb_decode_issue_ctrl;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    imm_type_e   out_imm_type;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_illegal;
`endif

    int checks;
    int failures;

    decode_issue_ctrl #(.DataWidth(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
`ifdef DECODE_PERF_CNT_EN
        .perf_issued  (perf_issued),
        .perf_illegal (perf_illegal),
`endif
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] imm, input logic [2:0] ty, input logic ill);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_type"}, 32'(out_imm_type), 32'(ty));
        chk({tag, "_rd"}, 32'(out_rd), 32'(instr[11:7]));
        chk({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    logic [31:0] s_instr [4];
    logic [31:0] s_imm   [4];
    logic [2:0]  s_ty    [4];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;

        // reset held three cycles
        tick(); tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm", out_imm, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        rst = 1'b0;
        tick(); tick();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // addi x1,x0,-1
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 32'h0000_0100;
        tick();
        in_valid = 1'b0;
        chk_bundle("addi", 32'h0000_0100, 32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0);
        chk("addi_rs1", 32'(out_rs1), 32'd0);
        chk("addi_rs2", 32'(out_rs2), 32'd31);
        tick();
        chk("addi_gone", 32'(out_valid), 32'd0);

        // back-to-back stream sw / beq / lui / jal
        s_instr[0] = 32'h0020_A423; s_imm[0] = 32'h0000_0008; s_ty[0] = 3'd2;
        s_instr[1] = 32'hFE00_0EE3; s_imm[1] = 32'hFFFF_FFFC; s_ty[1] = 3'd3;
        s_instr[2] = 32'h1234_52B7; s_imm[2] = 32'h1234_5000; s_ty[2] = 3'd4;
        s_instr[3] = 32'h0000_006F; s_imm[3] = 32'h0000_0000; s_ty[3] = 3'd5;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = s_instr[i]; in_pc = 32'h0000_0200 + 32'(i * 4);
            tick();
            chk_bundle("stream", 32'h0000_0200 + 32'(i * 4), s_instr[i], s_imm[i], s_ty[i], 1'b0);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        chk("sw_rs1", 32'(out_rs1), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("stream_end", 32'(out_valid), 32'd0);

        // backpressure: two entries fill, outputs hold, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0050_0113; in_pc = 32'h0000_0300;
        tick();
        chk("bp_ready1", 32'(in_ready), 32'd1);
        in_instr = 32'h00C0_0193; in_pc = 32'h0000_0304;
        tick();
        in_valid = 1'b0;
        chk("bp_ready2", 32'(in_ready), 32'd0);
        chk_bundle("bp_hold1", 32'h0000_0300, 32'h0050_0113, 32'h0000_0005, 3'd1, 1'b0);
        tick();
        chk_bundle("bp_hold2", 32'h0000_0300, 32'h0050_0113, 32'h0000_0005, 3'd1, 1'b0);
        chk("bp_ready3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk_bundle("bp_second", 32'h0000_0304, 32'h00C0_0193, 32'h0000_000C, 3'd1, 1'b0);
        chk("bp_ready4", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // illegal encodings are delivered, not dropped
        in_valid = 1'b1; in_instr = 32'h0000_0000; in_pc = 32'h0000_0400;
        tick();
        chk_bundle("ill0", 32'h0000_0400, 32'h0000_0000, 32'h0, 3'd0, 1'b1);
        in_instr = 32'h0000_007F; in_pc = 32'h0000_0404;
        tick();
        chk_bundle("ill7f", 32'h0000_0404, 32'h0000_007F, 32'h0, 3'd0, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("ill_empty", 32'(out_valid), 32'd0);
`ifdef DECODE_PERF_CNT_EN
        chk("perf_illegal", perf_illegal, 32'd2);
        chk("perf_issued", perf_issued, 32'd9);
`endif

        // flush with both entries full and a same-cycle input
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h0000_0500;
        tick();
        in_instr = 32'h0020_0093; in_pc = 32'h0000_0504;
        tick();
        chk("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1; in_instr = 32'h0030_0093; in_pc = 32'h0000_0508;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick(); tick();
        chk("fl_nothing", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_instr = 32'h0040_0093; in_pc = 32'h0000_0600;
        tick();
        in_valid = 1'b0;
        chk_bundle("fl_after", 32'h0000_0600, 32'h0040_0093, 32'h0000_0004, 3'd1, 1'b0);
        tick();
        chk("fl_after_gone", 32'(out_valid), 32'd0);
`ifdef DECODE_PERF_CNT_EN
        chk("perf_issued_fl", perf_issued, 32'd10);
`endif

        // reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h0000_0700;
        tick();
        in_instr = 32'h0060_0093; in_pc = 32'h0000_0704;
        tick();
        rst = 1'b1; in_instr = 32'h0070_0093;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_imm", out_imm, 32'h0);
        chk("mrst_instr", out_instr, 32'h0);
        chk("mrst_pc", out_pc, 32'h0);
        chk("mrst_rd", 32'(out_rd), 32'd0);
`ifdef DECODE_PERF_CNT_EN
        chk("mrst_perf_issued", perf_issued, 32'd0);
        chk("mrst_perf_illegal", perf_illegal, 32'd0);
`endif
        tick();
        chk("mrst_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- RV32I decode-stage controller between fetch and execute.
- Classifies each instruction's opcode and selects the immediate format (I/S/B/U/J/none).
- Drives the team's immediate_generation datapath and registers the selected immediate with register indices.
- Valid/ready handshake on both sides; 2-entry skid buffer gives full throughput under backpressure; synchronous flush for branch redirect.

Parameters:
- DataWidth, 32, instruction/PC/immediate width (fixed at 32 for RV32I).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries (redirect)
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept
- in_instr  in  DataWidth  instruction word
- in_pc  in  DataWidth  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  DataWidth  PC passthrough
- out_instr  out  DataWidth  instruction passthrough
- out_imm  out  DataWidth  selected sign-extended immediate
- out_imm_type  out  3  rv32i_pkg::imm_type_e
- out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7] / [19:15] / [24:20]
- out_illegal  out  1  unsupported opcode or instr[1:0] != 2'b11

Behaviour:
- Reset: out_valid=0, all out_* data=0, in_ready=1, both buffer entries invalid. rst has priority over flush and handshakes.
- Transfers occur on valid&&ready at the rising edge. Latency: accepted instruction appears on out_* the next cycle.
- Buffer: main register (drives out_*) plus skid register.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Main empty or draining: input loads main.
  - Main full and not draining: input loads skid.
  - Main drains while skid full: skid moves to main.
- Order preserved; no bubble under continuous flow with out_ready=1.
- out_* stable while out_valid && !out_ready.
- Opcode (instr[6:0]) to immediate type:
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - 0110011 -> NONE, imm=0
  - anything else -> NONE, imm=0, illegal=1
- Decode is combinational on in_instr; the result is captured into the buffer entry (imm computed pre-register).
- Illegal instructions are still passed downstream with out_illegal=1, never dropped.
- flush: clears main and skid valid next cycle. Same-cycle in_valid is dropped, regardless of in_ready. Same-cycle output handshake still counts as delivered. in_ready=1 the cycle after flush.

Optional Feature:
- Macro DECODE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_issued [31:0] and perf_illegal [31:0].
  - perf_issued increments on each output handshake; perf_illegal increments on each output handshake with out_illegal=1.
  - Both counters wrap at 2^32 and reset to 0 on rst; flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- rv32i_pkg holds:
  - typedef enum logic [2:0] imm_type_e {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}
  - opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_SYSTEM, OPC_FENCE)
  - typedef struct packed dec_bundle_t {pc, instr, imm, imm_type, rd, rs1, rs2, illegal}
- Sub-module decode_skid_buf, parameterised on dec_bundle_t, implements the 2-entry buffer and flush.
- Top instantiates immediate_generation plus an opcode-select mux.

Test Plan:
- rst held 3 cycles -> out_valid=0, in_ready=1, out_imm=0; release, no input -> out_valid stays 0.
- Send 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, type IMM_I, rd=1, rs1=0, illegal=0.
- Back-to-back stream 0x0020A423 (sw), 0xFE000EE3 (beq -4), 0x123452B7 (lui), 0x0000006F (jal 0) -> imm 0x00000008 S, 0xFFFFFFFC B, 0x12345000 U, 0x00000000 J, one per cycle, no bubbles.
- out_ready=0, push 2 instrs -> in_ready=0 after second, out_* stable. Raise out_ready -> both delivered in order; in_ready returns to 1 one cycle after the first drain.
- 0x00000000 and 0x0000007F -> out_illegal=1, type IMM_NONE, imm=0, still delivered. With DECODE_PERF_CNT_EN -> perf_illegal=2.
- Fill both entries, assert flush with in_valid=1 -> out_valid=0 next cycle, flushed and dropped instrs never appear, in_ready=1; rst asserted mid-stream -> same as reset state.
